// File: rtl/mult_switch_pkg.sv
// mult_switch_pkg: shared mode encodings, select-width helper and pipeline tag
package mult_switch_pkg;

    typedef enum logic {
        MODE_MULT = 1'b0,
        MODE_MAC  = 1'b1
    } mode_e;

    typedef struct packed {
        logic  valid;
        mode_e mode;
        logic  last;
    } tag_t;

    function automatic int sel_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mult_switch_mac_pipe.sv
// mult_pipe: signed multiplier pipeline of MULT_LAT stages carrying a tag alongside
module mult_pipe
    import mult_switch_pkg::*;
#(
    parameter int IN_DATA_TYPE = 16,
    parameter int MULT_LAT     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  tag_t                      i_tag,
    input  logic [IN_DATA_TYPE-1:0]   i_a,
    input  logic [IN_DATA_TYPE-1:0]   i_b,
    output logic                      o_valid,
    output tag_t                      o_tag,
    output logic [2*IN_DATA_TYPE-1:0] o_p
);

    logic [2*IN_DATA_TYPE-1:0] p [MULT_LAT];
    tag_t                      t [MULT_LAT];

    // Product data is never reset or gated; only the valid bit qualifies it.
    always_ff @(posedge clk) begin
        p[0] <= $signed(i_a) * $signed(i_b);
        for (int i = 1; i < MULT_LAT; i++) p[i] <= p[i-1];
        if (rst) begin
            for (int i = 0; i < MULT_LAT; i++) t[i] <= '0;
        end else begin
            t[0] <= '{valid: i_valid & i_tag.valid, mode: i_tag.mode, last: i_tag.last};
            for (int i = 1; i < MULT_LAT; i++) t[i] <= t[i-1];
        end
    end

    assign o_valid = t[MULT_LAT-1].valid;
    assign o_tag   = t[MULT_LAT-1];
    assign o_p     = p[MULT_LAT-1];

endmodule

// File: rtl/mult_switch_mac.sv
// mult_switch_mac: stationary-operand multiply switch with per-beat MULT/MAC output
module mult_switch_mac
    import mult_switch_pkg::*;
#(
    parameter int IN_DATA_TYPE  = 16,
    parameter int OUT_DATA_TYPE = 32,
    parameter int BUF_DEPTH     = 4,
    parameter int MULT_LAT      = 2,
    parameter int SEL_W         = sel_width(BUF_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [IN_DATA_TYPE-1:0]  i_data,
    input  logic                     i_stationary,
    input  logic [SEL_W-1:0]         i_sel,
    input  logic                     i_acc_mode,
    input  logic                     i_acc_last,
    input  logic                     i_clear,
    output logic                     o_valid,
    output logic [OUT_DATA_TYPE-1:0] o_data,
    output logic [BUF_DEPTH-1:0]     o_buf_valid,
    output logic                     o_drop
);

    logic [IN_DATA_TYPE-1:0]    entry [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]       buf_valid;
    logic                       load, stream, hit;
    logic                       pv;
    tag_t                       ptag;
    logic [2*IN_DATA_TYPE-1:0]  pp;
    logic [OUT_DATA_TYPE-1:0]   prod, sum, acc;
    logic                       first;

    assign load        = i_valid & i_stationary;
    assign stream      = i_valid & ~i_stationary;
    assign hit         = stream & buf_valid[i_sel];
    assign o_buf_valid = buf_valid;

    // A load issued together with a clear wins for its own entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) entry[i] <= '0;
            buf_valid <= '0;
            o_drop    <= 1'b0;
        end else begin
            if (i_clear) buf_valid <= '0;
            if (load) begin
                entry[i_sel]     <= i_data;
                buf_valid[i_sel] <= 1'b1;
            end
            o_drop <= stream & ~buf_valid[i_sel];
        end
    end

    mult_pipe #(
        .IN_DATA_TYPE(IN_DATA_TYPE),
        .MULT_LAT    (MULT_LAT)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_valid(hit),
        .i_tag  ('{valid: hit, mode: mode_e'(i_acc_mode), last: i_acc_last}),
        .i_a    (i_data),
        .i_b    (entry[i_sel]),
        .o_valid(pv),
        .o_tag  (ptag),
        .o_p    (pp)
    );

    assign prod = OUT_DATA_TYPE'($signed(pp));
    assign sum  = (first ? '0 : acc) + prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            acc     <= '0;
            first   <= 1'b1;
        end else begin
            o_valid <= pv & ptag.valid & (ptag.mode == MODE_MULT | ptag.last);
            if (pv & ptag.valid) begin
                if (ptag.mode == MODE_MULT) begin
                    o_data <= prod;
                end else if (ptag.last) begin
                    o_data <= sum;
                    acc    <= '0;
                    first  <= 1'b1;
                end else begin
                    acc   <= sum;
                    first <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_switch_mac.sv
// tb_mult_switch_mac: directed stimulus with a queue scoreboard checked by an output monitor
module tb_mult_switch_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [15:0] i_data = '0;
    logic        i_stationary = 1'b0;
    logic [1:0]  i_sel = '0;
    logic        i_acc_mode = 1'b0;
    logic        i_acc_last = 1'b0;
    logic        i_clear = 1'b0;
    logic        o_valid;
    logic [31:0] o_data;
    logic [3:0]  o_buf_valid;
    logic        o_drop;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    int   drop_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    mult_switch_mac dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_stationary(i_stationary),
        .i_sel       (i_sel),
        .i_acc_mode  (i_acc_mode),
        .i_acc_last  (i_acc_last),
        .i_clear     (i_clear),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_buf_valid (o_buf_valid),
        .o_drop      (o_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got %h at cycle %0d, required no output", o_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_data !== e.d || cyc != e.c) begin
                    n_fail++;
                    $display("FAIL out_data: got %h at cycle %0d, required %h at cycle %0d", o_data, cyc, e.d, e.c);
                end
            end
        end
        if (o_drop) begin
            n_chk++;
            if (drop_q.size() == 0) begin
                n_fail++;
                $display("FAIL drop_unexpected: o_drop at cycle %0d, required none", cyc);
            end else begin
                int c;
                c = drop_q.pop_front();
                if (cyc != c) begin
                    n_fail++;
                    $display("FAIL drop_cycle: o_drop at cycle %0d, required cycle %0d", cyc, c);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_stationary = 1'b0;
        i_clear = 1'b0;
        i_acc_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic load(input int sel, input int data, input logic clr);
        i_valid = 1'b1;
        i_stationary = 1'b1;
        i_sel = 2'(sel);
        i_data = 16'(data);
        i_clear = clr;
        step();
    endtask

    task automatic clear();
        i_clear = 1'b1;
        step();
    endtask

    task automatic stream(input int sel, input int data, input logic mode, input logic last,
                          input logic push, input logic [31:0] exp);
        i_valid = 1'b1;
        i_stationary = 1'b0;
        i_sel = 2'(sel);
        i_data = 16'(data);
        i_acc_mode = mode;
        i_acc_last = last;
        if (push) exp_q.push_back('{d: exp, c: cyc + 3});
        step();
    endtask

    task automatic stream_drop(input int sel, input int data);
        i_valid = 1'b1;
        i_stationary = 1'b0;
        i_sel = 2'(sel);
        i_data = 16'(data);
        i_acc_mode = 1'b0;
        drop_q.push_back(cyc + 1);
        step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1;
        do_reset(3);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", o_data, 32'd0);
        chk("rst_o_drop", 32'(o_drop), 32'd0);
        chk("rst_buf_valid", 32'(o_buf_valid), 32'd0);

        load(2, 3, 1'b0);
        load(0, -2, 1'b0);
        chk("buf_valid_loads", 32'(o_buf_valid), 32'h5);
        stream(2, 5, 1'b0, 1'b0, 1'b1, 32'd15);
        stream(0, 7, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF2);
        idle(4);

        load(1, 4, 1'b0);
        stream(1, 1, 1'b1, 1'b0, 1'b0, 32'd0);
        stream(1, 2, 1'b1, 1'b0, 1'b0, 32'd0);
        stream(1, 3, 1'b1, 1'b1, 1'b1, 32'd24);
        stream(1, 10, 1'b1, 1'b1, 1'b1, 32'd40);
        idle(4);

        stream_drop(3, 9);
        idle(4);
        clear();
        chk("buf_valid_clear", 32'(o_buf_valid), 32'd0);
        stream_drop(2, 5);
        idle(4);

        load(0, 6, 1'b0);
        stream(0, 2, 1'b0, 1'b0, 1'b1, 32'd12);
        idle(4);
        load(1, 5, 1'b1);
        chk("buf_valid_clear_load", 32'(o_buf_valid), 32'h2);

        load(3, -32768, 1'b0);
        stream(3, -32768, 1'b1, 1'b0, 1'b0, 32'd0);
        stream(3, -32768, 1'b1, 1'b0, 1'b0, 32'd0);
        stream(1, 2, 1'b0, 1'b0, 1'b1, 32'd10);
        stream(3, -32768, 1'b1, 1'b1, 1'b1, 32'hC000_0000);
        idle(5);

        stream(3, -32768, 1'b1, 1'b0, 1'b0, 32'd0);
        stream(3, -32768, 1'b1, 1'b0, 1'b0, 32'd0);
        do_reset(2);
        chk("midrst_buf_valid", 32'(o_buf_valid), 32'd0);
        chk("midrst_o_data", o_data, 32'd0);
        stream_drop(3, 1);
        load(1, 2, 1'b0);
        stream(1, 3, 1'b1, 1'b1, 1'b1, 32'd6);
        idle(8);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("drop_q_empty", 32'(drop_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_switch_mac.md
Name: mult_switch_mac

Overview:
- Next-generation multiply switch for the distribution/reduction fabric.
- Holds BUF_DEPTH stationary operands in a local register file, selected per beat.
- Multiplies each streaming operand against the selected entry through an in-RTL signed multiplier pipeline, with no vendor IP.
- Per-beat mode: emit each product (MULT mode) or accumulate products until a tagged last beat (MAC mode). Sits between the distribution network leaf and the reduction network input.

Parameters:
- IN_DATA_TYPE, 16, operand width in bits, two's complement.
- OUT_DATA_TYPE, 32, output/accumulator width in bits; must be >= 2*IN_DATA_TYPE.
- BUF_DEPTH, 4, number of stationary buffer entries; power of two, >= 2.
- MULT_LAT, 2, multiplier pipeline stages; legal range 1..4.
- SEL_W, $clog2(BUF_DEPTH), width of the entry select.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  input beat valid.
- i_data  in  IN_DATA_TYPE  operand (stationary or streaming).
- i_stationary  in  1  beat is a stationary load into entry i_sel.
- i_sel  in  SEL_W  buffer entry to load (stationary) or to multiply against (streaming).
- i_acc_mode  in  1  0 = MULT, 1 = MAC; sampled per streaming beat.
- i_acc_last  in  1  MAC beat closes the current accumulation.
- i_clear  in  1  invalidate all buffer entries.
- o_valid  out  1  output valid.
- o_data  out  OUT_DATA_TYPE  product or accumulated sum.
- o_buf_valid  out  BUF_DEPTH  per-entry valid flags.
- o_drop  out  1  one-cycle pulse: streaming beat addressed an invalid entry.

Behaviour:
- Reset:
  - o_valid=0, o_data=0, o_drop=0, o_buf_valid=0.
  - All buffer entries = 0.
  - Pipeline valid bits cleared, accumulator = 0, first-flag = 1.
  - Reset mid-operation discards in-flight products and any partial sum; no output is produced for them.
- Stationary load (i_valid & i_stationary):
  - entry[i_sel] <= i_data; valid[i_sel] <= 1 at the next edge.
  - No multiply is issued that cycle.
  - A streaming beat on the following cycle sees the new value.
- Streaming beat (i_valid & ~i_stationary):
  - If valid[i_sel]=1: issue i_data * entry[i_sel] into the pipeline, tagged with {i_acc_mode, i_acc_last}.
  - If valid[i_sel]=0: beat is dropped and o_drop pulses 1 on the next cycle. Nothing enters the pipeline.
- i_clear:
  - All valid flags go to 0 at the next edge; entry data is retained.
  - If asserted with a stationary load, the load wins for its entry, which ends valid=1 and all others 0.
  - In-flight products are unaffected.
- Multiplier:
  - Signed IN x IN -> 2*IN product, sign-extended to OUT_DATA_TYPE.
  - Fully pipelined: one issue per cycle, result at pipeline output MULT_LAT cycles after issue.
  - Operands are not gated to zero when idle; only the valid bit travels.
- Output stage (one registered stage after pipeline output), for a product P with tags (mode, last):
  - MULT mode: o_data <= P, o_valid <= 1. Total issue-to-o_valid latency is MULT_LAT+1 cycles. The accumulator is untouched.
  - MAC mode: sum = (first ? 0 : acc) + P, wrapping modulo 2^OUT_DATA_TYPE.
    - If last: o_data <= sum, o_valid <= 1, acc <= 0, first <= 1.
    - Else: acc <= sum, first <= 0, o_valid <= 0.
  - MULT products interleaved inside an open MAC sequence pass through without disturbing acc/first.
  - A MAC sequence of a single beat with last=1 outputs that product.
  - o_data holds its last value when o_valid=0.
- No backpressure; the downstream consumer must accept every o_valid cycle.
- Throughput: one output per cycle in MULT mode.

Decomposition:
- Package mult_switch_pkg:
  - mode encodings MODE_MULT=1'b0, MODE_MAC=1'b1;
  - a localparam helper for SEL_W;
  - a pipeline tag struct {valid, mode, last}.
- Sub-module mult_pipe:
  - parameters IN_DATA_TYPE, MULT_LAT;
  - ports clk, rst, i_valid, i_tag, i_a, i_b, o_valid, o_tag, o_p;
  - signed multiplier with MULT_LAT register stages carrying the tag alongside.
- The top level holds the buffer, select/drop logic and accumulator.

Test Plan:
- Reset, then load entry2=3 and entry0=-2; stream 5 @sel2 MULT -> o_valid at issue+MULT_LAT+1 with o_data=15. Then stream 7 @sel0 -> o_data=-14 sign-extended (0xFFFFFFF2).
- MAC: entry1=4; stream 1,2,3 @sel1 with last on the third beat -> exactly one o_valid with o_data=24; an immediately following MAC beat 10 with last -> o_data=40, proving the accumulator restarted.
- Stream @sel3 with entry3 never loaded -> o_drop=1 for one cycle, no o_valid. i_clear after entry2 load -> o_buf_valid=0, and the next stream @sel2 is dropped.
- Back-to-back: stationary load entry0=6 at cycle t, stream 2 @sel0 at t+1 -> o_data=12. Also i_clear and a load of entry1 in the same cycle -> o_buf_valid=4'b0010.
- Wrap: OUT=32, entry=-32768, stream -32768 MAC for 3 beats -> o_data = 3*2^30 mod 2^32 = 0xC0000000.
- Reset asserted with 2 MAC beats in flight -> no o_valid. After reset, stationary entries are invalid and the next MAC sequence starts from 0.
